fetch_redirect_ctrl: RTL
========================

Name: fetch_redirect_ctrl

Overview:
- Sequences the instruction-fetch front end: owns the fetch PC register and arbitrates redirect sources (exception, ertn, TLB-refetch flush, branch).
- Issues requests on the inst_sram request/addr_ok/data_ok interface, tracking up to MAX_OUTSTANDING in-flight requests.
- On a redirect, marks all in-flight responses stale and drops them, so only correct-path instructions reach the IF stage.
- Sits between the CSR/ID redirect buses and the instruction SRAM bridge, in front of the IF stage.

Parameters:
RESET_PC, 32'h1c000000, fetch address after reset
MAX_OUTSTANDING, 2, maximum accepted-but-unreturned requests (2..4)
CNT_W, 2, width of the in-flight and cancel counters; must hold MAX_OUTSTANDING

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
excep_en_i  in  1  exception redirect
excep_pc_i  in  32  exception entry PC
ertn_en_i  in  1  ertn redirect
ertn_pc_i  in  32  ertn return PC
tlb_flush_en_i  in  1  TLB-refetch redirect
tlb_flush_pc_i  in  32  refetch PC
branch_en_i  in  1  branch redirect from ID
branch_pc_i  in  32  branch target
next_allowin_i  in  1  IF stage can accept a new request
inst_sram_req_o  out  1  fetch request
inst_sram_addr_o  out  32  fetch address
inst_sram_addr_ok_i  in  1  request accepted
inst_sram_data_ok_i  in  1  response data valid
inst_sram_rdata_i  in  32  response data
to_if_valid_o  out  1  valid correct-path instruction this cycle
to_if_pc_o  out  32  PC of delivered instruction
to_if_inst_o  out  32  delivered instruction
busy_o  out  1  in-flight count nonzero or pending redirect held

Behaviour:
- Reset (asynchronous, active-high):
  - pc_q = RESET_PC; pending_vld = 0; inflight = 0; cancel = 0; PC FIFO empty.
  - Outputs: inst_sram_req_o = 0, to_if_valid_o = 0, busy_o = 0.
- Same-cycle redirect priority: excep > ertn > tlb_flush > branch. The winner gives redir_vld and redir_pc.
- Address select: inst_sram_addr_o = redir_pc if redir_vld; else pending_pc if pending_vld; else pc_q.
- Request: inst_sram_req_o = next_allowin_i && (inflight < MAX_OUTSTANDING) && !rst. Request is combinational, with zero-cycle issue latency.
- Accept: accept = req && addr_ok.
  - On accept: pc_q <= issued address + 4; pending_vld <= 0; push the issued address into the PC FIFO; inflight++.
  - No accept: pc_q holds.
- Redirect not accepted in its own cycle:
  - The redirect is latched: pending_vld <= 1, pending_pc <= redir_pc, pending_src <= winning source.
  - A later excep/ertn/tlb_flush always overwrites pending.
  - A later branch overwrites pending only when pending_src == branch; otherwise it is ignored.
- Stale-response cancel, on any cycle with redir_vld:
  - cancel <= inflight + accept_old_path − data_ok_consumed_this_cycle.
  - accept_old_path is always 0, because an accepted address in a redirect cycle is the redirect target.
  - If cancel was already nonzero, the same formula applies with the current counts, i.e. every in-flight response is stale.
  - The PC FIFO is not flushed; stale entries pop on their data_ok.
- Response handling on data_ok:
  - Pop the PC FIFO; inflight--.
  - If cancel > 0 (after any same-cycle update): to_if_valid_o = 0 and cancel--.
  - Otherwise: to_if_valid_o = 1, to_if_pc_o = FIFO head, to_if_inst_o = rdata.
  - Delivery is combinational from data_ok, so response-to-IF latency is 0 cycles.
- Simultaneous accept and data_ok: inflight is unchanged and the FIFO pushes and pops in the same cycle. This must work with the FIFO full, since a pop frees a slot, but req still uses the registered inflight.
- Invariants:
  - inflight never exceeds MAX_OUTSTANDING.
  - cancel ≤ inflight at all times.
  - data_ok with inflight == 0 is a protocol violation; ignore it (no pop, no valid).
- FSM (encodes pending/cancel):
  - RUN: sequential fetch.
  - REDIR_HOLD: pending_vld = 1 and waiting for accept.
  - DRAIN: cancel > 0. Requests may still issue; new-path responses return after stale ones, in order.
  - Priority of state encoding: REDIR_HOLD over DRAIN.
- Reset mid-operation: all state is cleared immediately. Responses arriving after reset from earlier requests are ignored under the inflight == 0 rule.

Test Plan:
- Reset release with next_allowin_i = 1 and addr_ok always 1 → addresses 0x1c000000, 0x1c000004, 0x1c000008 on consecutive cycles; with data_ok one cycle later, to_if_pc_o follows the same sequence and valid is 1.
- Two requests accepted and unreturned, then branch_en_i = 1 with branch_pc_i = 0x1c000100 → both responses dropped (valid 0); the first valid delivery has pc 0x1c000100; inflight never exceeds 2.
- excep_en_i and branch_en_i in the same cycle (excep_pc 0x1c008000, branch 0x1c000100) → address 0x1c008000 is issued.
- Redirect while addr_ok = 0 for 3 cycles, branch again in cycle 2 while pending_src = excep → address stays at the exception PC until accept; the branch is ignored; pc_q = excep_pc + 4 after accept.
- next_allowin_i = 0 for 4 cycles → req 0, address held, pc unchanged; busy_o reflects inflight.
- Assert rst with 2 in flight, deassert, then inject 2 data_ok → no to_if_valid_o; the fetch restarts at 0x1c000000.

Source files
------------

// File: rtl/fetch_redirect_ctrl.sv
// Fetch front-end sequencer: owns the fetch PC, arbitrates redirects, issues inst_sram
// requests and drops responses that belong to a path abandoned by a redirect.
module fetch_redirect_ctrl #(
    parameter logic [31:0] RESET_PC        = 32'h1c000000,
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter int unsigned CNT_W           = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        excep_en_i,
    input  logic [31:0] excep_pc_i,
    input  logic        ertn_en_i,
    input  logic [31:0] ertn_pc_i,
    input  logic        tlb_flush_en_i,
    input  logic [31:0] tlb_flush_pc_i,
    input  logic        branch_en_i,
    input  logic [31:0] branch_pc_i,
    input  logic        next_allowin_i,
    output logic        inst_sram_req_o,
    output logic [31:0] inst_sram_addr_o,
    input  logic        inst_sram_addr_ok_i,
    input  logic        inst_sram_data_ok_i,
    input  logic [31:0] inst_sram_rdata_i,
    output logic        to_if_valid_o,
    output logic [31:0] to_if_pc_o,
    output logic [31:0] to_if_inst_o,
    output logic        busy_o
);

    localparam int unsigned PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    typedef enum logic [1:0] {SrcExcep, SrcErtn, SrcTlb, SrcBranch} src_e;
    typedef enum logic [1:0] {StRun, StRedirHold, StDrain} state_e;

    logic [31:0]      pc_q, pc_d;
    logic             pending_vld_q, pending_vld_d;
    logic [31:0]      pending_pc_q, pending_pc_d;
    src_e             pending_src_q, pending_src_d;
    logic [CNT_W-1:0] inflight_q, inflight_d;
    logic [CNT_W-1:0] cancel_q, cancel_d;
    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [31:0]      fifo_q [MAX_OUTSTANDING];
    state_e           state_q, state_d;

    logic             redir_vld;
    logic [31:0]      redir_pc;
    src_e             redir_src;
    logic             branch_blocked;
    logic             accept;
    logic             resp_vld;
    logic             resp_drop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
    endfunction

    // A branch may not displace a held higher-priority redirect.
    always_comb begin
        branch_blocked = pending_vld_q && (pending_src_q != SrcBranch);
        redir_vld      = 1'b1;
        redir_pc       = excep_pc_i;
        redir_src      = SrcExcep;
        if (excep_en_i) begin
            redir_pc  = excep_pc_i;
            redir_src = SrcExcep;
        end else if (ertn_en_i) begin
            redir_pc  = ertn_pc_i;
            redir_src = SrcErtn;
        end else if (tlb_flush_en_i) begin
            redir_pc  = tlb_flush_pc_i;
            redir_src = SrcTlb;
        end else if (branch_en_i && !branch_blocked) begin
            redir_pc  = branch_pc_i;
            redir_src = SrcBranch;
        end else begin
            redir_vld = 1'b0;
            redir_pc  = branch_pc_i;
            redir_src = SrcBranch;
        end
    end

    always_comb begin
        inst_sram_req_o  = next_allowin_i && (inflight_q < CNT_W'(MAX_OUTSTANDING)) && !rst;
        inst_sram_addr_o = redir_vld     ? redir_pc     :
                           pending_vld_q ? pending_pc_q : pc_q;
        accept           = inst_sram_req_o && inst_sram_addr_ok_i;
        // data_ok with nothing in flight is a protocol violation and is ignored.
        resp_vld         = inst_sram_data_ok_i && (inflight_q != '0);
        // A response returning in a redirect cycle is itself old-path.
        resp_drop        = redir_vld || (cancel_q != '0);
        to_if_valid_o    = resp_vld && !resp_drop;
        to_if_pc_o       = fifo_q[rptr_q];
        to_if_inst_o     = inst_sram_rdata_i;
        busy_o           = (inflight_q != '0) || (state_q == StRedirHold);
    end

    always_comb begin
        pc_d          = accept ? inst_sram_addr_o + 32'd4 : pc_q;
        pending_vld_d = pending_vld_q;
        pending_pc_d  = pending_pc_q;
        pending_src_d = pending_src_q;
        if (accept) begin
            pending_vld_d = 1'b0;
        end else if (redir_vld) begin
            pending_vld_d = 1'b1;
            pending_pc_d  = redir_pc;
            pending_src_d = redir_src;
        end

        inflight_d = inflight_q + CNT_W'(accept) - CNT_W'(resp_vld);

        // Everything still in flight at a redirect is stale; the FIFO drains naturally.
        if (redir_vld) begin
            cancel_d = inflight_q - CNT_W'(resp_vld);
        end else if (resp_vld && (cancel_q != '0)) begin
            cancel_d = cancel_q - 1'b1;
        end else begin
            cancel_d = cancel_q;
        end

        wptr_d = accept   ? ptr_inc(wptr_q) : wptr_q;
        rptr_d = resp_vld ? ptr_inc(rptr_q) : rptr_q;

        if (pending_vld_d) begin
            state_d = StRedirHold;
        end else if (cancel_d != '0) begin
            state_d = StDrain;
        end else begin
            state_d = StRun;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q          <= RESET_PC;
            pending_vld_q <= 1'b0;
            pending_pc_q  <= '0;
            pending_src_q <= SrcBranch;
            inflight_q    <= '0;
            cancel_q      <= '0;
            wptr_q        <= '0;
            rptr_q        <= '0;
            state_q       <= StRun;
            for (int i = 0; i < int'(MAX_OUTSTANDING); i++) begin
                fifo_q[i] <= '0;
            end
        end else begin
            pc_q          <= pc_d;
            pending_vld_q <= pending_vld_d;
            pending_pc_q  <= pending_pc_d;
            pending_src_q <= pending_src_d;
            inflight_q    <= inflight_d;
            cancel_q      <= cancel_d;
            wptr_q        <= wptr_d;
            rptr_q        <= rptr_d;
            state_q       <= state_d;
            if (accept) begin
                fifo_q[wptr_q] <= inst_sram_addr_o;
            end
        end
    end

endmodule
